// File: rtl/ip_csum_seq.sv
// rtl/ip_csum_seq.sv - IPv4 header checksum sequencer feeding an external 9-input adder tree
//
// Collects the ten 16-bit words of an IPv4 header. The word at SKIP_IDX (the
// checksum field) is dropped, and the other nine are registered onto op_a..op_i
// in arrival order. After the last word it waits TREE_LAT clock edges for the
// external one's-complement tree, captures tree_sum, and holds it until the
// downstream side accepts it.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   hdr_data/valid/sop    header word stream in; hdr_ready is the accept side
//   op_a..op_i            registered operands to the adder tree
//   tree_sum              complemented checksum from the tree
//   csum_data/valid/ready checksum result handshake
//   busy                  high whenever a frame is in progress
//   csum_count            number of checksums handed off (wraps)
module ip_csum_seq #(
  parameter int TREE_LAT = 6,
  parameter int SKIP_IDX = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] hdr_data,
  input  logic        hdr_valid,
  input  logic        hdr_sop,
  output logic        hdr_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [15:0] op_c,
  output logic [15:0] op_d,
  output logic [15:0] op_e,
  output logic [15:0] op_f,
  output logic [15:0] op_g,
  output logic [15:0] op_h,
  output logic [15:0] op_i,
  input  logic [15:0] tree_sum,
  output logic [15:0] csum_data,
  output logic        csum_valid,
  input  logic        csum_ready,
  output logic        busy,
  output logic [15:0] csum_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  word_idx;
  logic [7:0]  lat_cnt;
  logic [15:0] ops [9];

  logic        hdr_fire;
  logic        take;
  logic [3:0]  cur_idx;
  logic [3:0]  slot;

  // A sop word always lands at index 0, which also covers a restart mid-frame.
  // Operand slots close up over the skipped word so arrival order is preserved.
  always_comb begin
    hdr_fire = hdr_valid && hdr_ready;
    take     = 1'b0;
    cur_idx  = hdr_sop ? 4'd0 : word_idx;
    slot     = (cur_idx > 4'(SKIP_IDX)) ? (cur_idx - 4'd1) : cur_idx;
    if (hdr_fire) begin
      if (state == COLLECT) take = 1'b1;
      else if (state == IDLE && hdr_sop) take = 1'b1;
    end
  end

  assign op_a = ops[0];
  assign op_b = ops[1];
  assign op_c = ops[2];
  assign op_d = ops[3];
  assign op_e = ops[4];
  assign op_f = ops[5];
  assign op_g = ops[6];
  assign op_h = ops[7];
  assign op_i = ops[8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      word_idx   <= 4'd0;
      lat_cnt    <= 8'd0;
      for (int k = 0; k < 9; k++) ops[k] <= 16'd0;
      csum_data  <= 16'd0;
      csum_valid <= 1'b0;
      csum_count <= 16'd0;
      busy       <= 1'b0;
      // Held low through reset so the first edge after release raises it.
      hdr_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          hdr_ready <= 1'b1;
          if (take) begin
            if (cur_idx != 4'(SKIP_IDX)) ops[slot] <= hdr_data;
            busy <= 1'b1;
            if (cur_idx == 4'd9) begin
              state     <= WAIT;
              lat_cnt   <= 8'd0;
              word_idx  <= 4'd0;
              hdr_ready <= 1'b0;
            end else begin
              state    <= COLLECT;
              word_idx <= cur_idx + 4'd1;
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt + 8'd1;
          // lat_cnt was cleared on the last-word edge, so it reads TREE_LAT-1
          // just before the TREE_LAT-th edge after that one.
          if (lat_cnt == 8'(TREE_LAT - 1)) begin
            csum_data  <= tree_sum;
            csum_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (csum_ready) begin
            csum_valid <= 1'b0;
            csum_count <= csum_count + 16'd1;
            busy       <= 1'b0;
            hdr_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
